// File: rtl/fuzz_vector_sequencer.sv
// fuzz_vector_sequencer
//
// Stimulus scheduler for differential fuzz runs. A preloaded table of input
// vectors is played out one entry every HOLD clocks on `stim`, which feeds a
// reference netlist and a synthesized netlist of the same design. On the last
// clock of each hold window the two `y` results are compared and the
// reference result is folded into a rotate-XOR signature.
//
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   load_en/addr/data  table write port, honoured only while not running
//   num_vec            vectors to run, sampled at start, clamped to DEPTH
//   start              begin a run from IDLE or DONE (ignored when load_en=1)
//   stim               registered vector driven to both DUT copies
//   y_ref, y_dut       reference and synthesized DUT outputs
//   busy, done         run in progress / run finished (level until next start)
//   fail, first_idx    sticky mismatch flag and index of first bad vector
//   mis_cnt            number of mismatching vectors in this run
//   sig                rotate-left-1 XOR signature of sampled y_ref values

module fuzz_vector_sequencer #(
  parameter int IN_W  = 256,
  parameter int OUT_W = 481,
  parameter int DEPTH = 32,
  parameter int HOLD  = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [IN_W-1:0]  load_data,
  input  logic [AW:0]      num_vec,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] y_ref,
  input  logic [OUT_W-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [AW-1:0]    first_idx,
  output logic [AW:0]      mis_cnt,
  output logic [OUT_W-1:0] sig
);

  // hold_cnt needs at least one bit even when HOLD=1
  localparam int HW  = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int AW1 = AW + 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD - 1);
  localparam logic [AW:0]   DEPTH_N     = AW1'(DEPTH);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t             state;
  logic [IN_W-1:0]    table_mem [DEPTH];
  logic [AW:0]        n_lat;
  logic [AW-1:0]      idx;
  logic [AW-1:0]      idx_next;
  logic [HW-1:0]      hold_cnt;
  logic [AW:0]        n_clamped;
  logic               last_vec;
  logic               mismatch;
  logic [OUT_W-1:0]   sig_next;

  assign n_clamped = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
  assign idx_next  = idx + AW'(1);
  // n_lat is never zero while in APPLY, so n_lat-1 cannot wrap here
  assign last_vec  = ({1'b0, idx} == (n_lat - AW1'(1)));
  assign mismatch  = (y_ref != y_dut);
  assign sig_next  = {sig[OUT_W-2:0], sig[OUT_W-1]} ^ y_ref;

  // Vector table: not reset, so contents survive rst_n; writes are locked
  // out while a run is reading the table.
  always_ff @(posedge clk) begin
    if (load_en && (state != APPLY)) begin
      table_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stim      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      first_idx <= '0;
      mis_cnt   <= '0;
      sig       <= '0;
      idx       <= '0;
      hold_cnt  <= '0;
      n_lat     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // load_en takes priority over start in the same cycle
          if (start && !load_en) begin
            n_lat     <= n_clamped;
            fail      <= 1'b0;
            first_idx <= '0;
            mis_cnt   <= '0;
            sig       <= '0;
            idx       <= '0;
            if (n_clamped == '0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              stim  <= '0;
            end else begin
              state    <= APPLY;
              done     <= 1'b0;
              busy     <= 1'b1;
              stim     <= table_mem[0];
              hold_cnt <= HOLD_RELOAD;
            end
          end
        end
        APPLY: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
          end else begin
            // sample edge: stim has been stable for HOLD clocks
            sig <= sig_next;
            if (mismatch) begin
              mis_cnt <= mis_cnt + AW1'(1);
              if (!fail) begin
                fail      <= 1'b1;
                first_idx <= idx;
              end
            end
            if (last_vec) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              stim  <= '0;
            end else begin
              idx      <= idx_next;
              stim     <= table_mem[idx_next];
              hold_cnt <= HOLD_RELOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// tb_fuzz_vector_sequencer
//
// Bench for fuzz_vector_sequencer. A pair of stand-in DUT netlists is modelled
// from stim (y_ref is a fixed mixing function, y_dut equals it except where a
// selectable mismatch predicate flips bit 0). Each run pushes the expected
// per-cycle stim/busy/done trace and the final result into queues; a monitor
// pops and compares on every falling edge.

module tb_fuzz_vector_sequencer;

  localparam int IN_W  = 256;
  localparam int OUT_W = 481;
  localparam int DEPTH = 32;
  localparam int HOLD  = 2;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             load_en = 1'b0;
  logic [AW-1:0]    load_addr = '0;
  logic [IN_W-1:0]  load_data = '0;
  logic [AW:0]      num_vec = '0;
  logic             start = 1'b0;
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] y_ref;
  logic [OUT_W-1:0] y_dut;
  logic             busy;
  logic             done;
  logic             fail;
  logic [AW-1:0]    first_idx;
  logic [AW:0]      mis_cnt;
  logic [OUT_W-1:0] sig;

  int checks = 0;
  int errors = 0;

  // stand-in DUT pair configuration
  int              bad_mode = 0;
  logic [IN_W-1:0] bad_val = '0;
  bit              ref_one = 1'b0;
  logic            bad_now;

  logic [IN_W-1:0] tbl_m [DEPTH];

  typedef struct {
    logic [IN_W-1:0] stim;
    logic            busy;
    logic            done;
    bit              last;
  } cyc_t;

  typedef struct {
    logic             fail;
    logic [AW-1:0]    first_idx;
    logic [AW:0]      mis_cnt;
    logic [OUT_W-1:0] sig;
  } res_t;

  cyc_t cyc_q[$];
  res_t res_q[$];
  cyc_t mon_c;
  res_t mon_r;

  fuzz_vector_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .HOLD(HOLD), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start), .stim(stim),
    .y_ref(y_ref), .y_dut(y_dut), .busy(busy), .done(done), .fail(fail),
    .first_idx(first_idx), .mis_cnt(mis_cnt), .sig(sig)
  );

  always #5 clk = ~clk;

  assign bad_now = (bad_mode == 1) || ((bad_mode == 2) && (stim == bad_val)) ||
                   ((bad_mode == 3) && (^stim[7:0]));
  assign y_ref = ref_one ? OUT_W'(1) : {stim ^ {stim[127:0], stim[255:128]}, stim[224:0]};
  assign y_dut = y_ref ^ {{(OUT_W-1){1'b0}}, bad_now};

  function automatic logic [OUT_W-1:0] ref_of(input logic [IN_W-1:0] v);
    if (ref_one) return OUT_W'(1);
    return {v ^ {v[127:0], v[255:128]}, v[224:0]};
  endfunction

  function automatic bit is_bad(input logic [IN_W-1:0] v);
    case (bad_mode)
      1: return 1'b1;
      2: return v == bad_val;
      3: return ^v[7:0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one expected trace entry per falling edge while a run is tracked
  always @(negedge clk) begin
    if (rst_n && cyc_q.size() > 0) begin
      mon_c = cyc_q.pop_front();
      checkOutput("stim", stim, mon_c.stim);
      checkOutput("busy", busy, mon_c.busy);
      checkOutput("done", done, mon_c.done);
      if (mon_c.last) begin
        if (res_q.size() == 0) begin
          checkOutput("result_queue_empty", 1, 0);
        end else begin
          mon_r = res_q.pop_front();
          checkOutput("fail", fail, mon_r.fail);
          checkOutput("first_idx", first_idx, mon_r.first_idx);
          checkOutput("mis_cnt", mis_cnt, mon_r.mis_cnt);
          checkOutput("sig", sig, mon_r.sig);
        end
      end
    end
  end

  task automatic loadEntry(input int addr, input logic [IN_W-1:0] data);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = AW'(addr);
    load_data = data;
    tbl_m[addr] = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Start a run of `num` vectors and queue its expected trace and result
  task automatic applyStimulus(input int num);
    int   n;
    int   budget;
    res_t r;
    cyc_t c;
    n = (num > DEPTH) ? DEPTH : num;
    r.fail = 1'b0;
    r.first_idx = '0;
    r.mis_cnt = '0;
    r.sig = '0;
    for (int i = 0; i < n; i++) begin
      r.sig = ((r.sig << 1) | (r.sig >> (OUT_W - 1))) ^ ref_of(tbl_m[i]);
      if (is_bad(tbl_m[i])) begin
        if (!r.fail) r.first_idx = AW'(i);
        r.fail = 1'b1;
        r.mis_cnt = r.mis_cnt + 1'b1;
      end
    end
    res_q.push_back(r);
    @(negedge clk);
    num_vec = (AW+1)'(num);
    start   = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= n * HOLD; k++) begin
      c.stim = (k < n * HOLD) ? tbl_m[k / HOLD] : '0;
      c.busy = (k < n * HOLD);
      c.done = (k == n * HOLD);
      c.last = (k == n * HOLD);
      cyc_q.push_back(c);
    end
    #1 start = 1'b0;
    budget = n * HOLD + 10;
    while (cyc_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (cyc_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_timeout: %0d entries left, required 0", cyc_q.size());
      cyc_q.delete();
      res_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // reset values
    #2 rst_n = 1'b0;
    #3;
    checkOutput("rst_stim", stim, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_fail", fail, 0);
    checkOutput("rst_first_idx", first_idx, 0);
    checkOutput("rst_mis_cnt", mis_cnt, 0);
    checkOutput("rst_sig", sig, 0);
    @(negedge clk);
    rst_n = 1'b1;

    loadEntry(0, IN_W'(8'h11));
    loadEntry(1, IN_W'(8'h22));
    loadEntry(2, IN_W'(8'h33));
    for (int a = 3; a < DEPTH; a++) begin
      loadEntry(a, {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom});
    end

    // matching outputs, then a single mismatch on vector 1
    bad_mode = 0;
    applyStimulus(3);
    bad_mode = 2;
    bad_val  = IN_W'(8'h22);
    applyStimulus(3);
    // every vector mismatches, then a clean rerun clears everything
    bad_mode = 1;
    applyStimulus(3);
    bad_mode = 0;
    applyStimulus(3);
    // constant y_ref signature
    ref_one = 1'b1;
    applyStimulus(2);
    ref_one = 1'b0;
    // empty run and clamped run
    applyStimulus(0);
    bad_mode = 3;
    applyStimulus(40);
    // randomized runs with a few fresh table entries each time
    for (int r = 0; r < 4; r++) begin
      loadEntry($urandom_range(0, DEPTH - 1), {$urandom, $urandom, $urandom, $urandom,
                                               $urandom, $urandom, $urandom, $urandom});
      applyStimulus($urandom_range(0, 2 * DEPTH - 1));
    end
    applyStimulus(0);

    // load_en and start together: the write happens, the start does not
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = AW'(5);
    load_data = IN_W'(32'hCAFE_0005);
    tbl_m[5]  = IN_W'(32'hCAFE_0005);
    start     = 1'b1;
    num_vec   = (AW+1)'(3);
    @(negedge clk);
    load_en = 1'b0;
    start   = 1'b0;
    checkOutput("load_prio_busy", busy, 0);
    checkOutput("load_prio_done", done, 1);
    checkOutput("load_prio_stim", stim, 0);

    // mid-run reset with an ignored table write during APPLY
    bad_mode = 1;
    @(negedge clk);
    num_vec = (AW+1)'(3);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrun_busy", busy, 1);
    checkOutput("midrun_mis_cnt", mis_cnt, 1);
    load_en   = 1'b1;
    load_addr = '0;
    load_data = IN_W'(16'hDEAD);
    @(negedge clk);
    load_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst2_stim", stim, 0);
    checkOutput("rst2_busy", busy, 0);
    checkOutput("rst2_done", done, 0);
    checkOutput("rst2_fail", fail, 0);
    checkOutput("rst2_first_idx", first_idx, 0);
    checkOutput("rst2_mis_cnt", mis_cnt, 0);
    checkOutput("rst2_sig", sig, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    bad_mode = 0;
    applyStimulus(1);
    applyStimulus(5);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
